// File: rtl/udp_dram_write_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// udp_dram_write_ctrl_pkg
// Shared constants and types for the UDP-to-DRAM write controller:
//   - AXI4 encodings used on the write address / response channels
//   - DRAM page size that bursts must not cross
//   - write FSM state encoding
//   - small unsigned min helper used for burst length selection
// -----------------------------------------------------------------------------
package udp_dram_write_ctrl_pkg;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int PAGE_BYTES = 4096;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CALC = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5
  } wr_state_t;

  function automatic logic [10:0] min_u11(input logic [10:0] a, input logic [10:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/udp_dram_write_ctrl_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is always visible
// on rd_data while empty is low; rd_en pops it.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (empties the FIFO)
//   wr_en, wr_data   push; dropped when full unless a pop happens that cycle
//   rd_en, rd_data   pop / head word
//   count            number of stored entries (0..DEPTH)
//   full, empty      status
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push;
  logic             pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign count = count_reg;

  // A full FIFO that is popping this cycle frees a slot, so the push lands.
  assign pop  = rd_en && !empty;
  assign push = wr_en && (!full || pop);

  // Storage carries no reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/udp_dram_write_ctrl.sv
// -----------------------------------------------------------------------------
// udp_dram_write_ctrl
// Buffers payload words and write commands from the UDP payload receiver and
// turns each command into AXI4 INCR write bursts (one outstanding at a time)
// that never cross a 4 KB page.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   data_in/data_we            {wstrb[3:0], wdata[31:0]} push into data FIFO
//   ctrl_in/ctrl_we            {len[7:0] words, byte addr[31:0]} push into cmd FIFO
//   data_full, ctrl_full       FIFO status (no backpressure to the producer)
//   overflow                   sticky: a push hit a full FIFO
//   busy                       FSM active or a command is queued
//   m_axi_aw*/w*/b*            AXI4 write channels toward the DRAM controller
// Optional build macro DRAM_WR_ERR_CNT_EN adds err_cnt (saturating count of
// non-OKAY write responses) and err_flag (sticky on the same condition).
// -----------------------------------------------------------------------------
module udp_dram_write_ctrl
  import udp_dram_write_ctrl_pkg::*;
#(
  parameter int DATA_FIFO_DEPTH = 512,
  parameter int CMD_FIFO_DEPTH  = 4,
  parameter int MAX_BURST       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [35:0] data_in,
  input  logic        data_we,
  input  logic [39:0] ctrl_in,
  input  logic        ctrl_we,
  output logic        data_full,
  output logic        ctrl_full,
  output logic        overflow,
  output logic        busy,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
`ifdef DRAM_WR_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt,
  output logic        err_flag
`endif
);

  localparam int DCW = $clog2(DATA_FIFO_DEPTH) + 1;
  localparam int CCW = $clog2(CMD_FIFO_DEPTH) + 1;
  localparam logic [10:0] MAX_BURST_W = 11'(MAX_BURST);

  wr_state_t   state_reg, state_next;
  logic [8:0]  rem_reg;
  logic [8:0]  beats_reg;
  logic [8:0]  beat_cnt_reg;
  logic [31:0] addr_reg;
  logic [31:0] awaddr_reg;
  logic [7:0]  awlen_reg;
  logic        overflow_reg;

  logic [35:0]    data_head;
  logic [DCW-1:0] data_count;
  logic           data_empty;
  logic [39:0]    cmd_head;
  logic [CCW-1:0] cmd_count_unused;
  logic           cmd_empty;
  logic           data_pop;
  logic           cmd_pop;

  logic [12:0] room_bytes;
  logic [10:0] room_beats;
  logic [10:0] beats_wide;
  logic [8:0]  beats_calc;
  logic [8:0]  rem_after;
  logic        data_ready;
  logic        beat_last;
  logic        unused_bits;

  // ---------------------------------------------------------------- FIFOs
  sync_fifo #(.WIDTH(36), .DEPTH(DATA_FIFO_DEPTH)) u_data_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (data_we),
    .wr_data (data_in),
    .rd_en   (data_pop),
    .rd_data (data_head),
    .count   (data_count),
    .full    (data_full),
    .empty   (data_empty)
  );

  sync_fifo #(.WIDTH(40), .DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ctrl_we),
    .wr_data (ctrl_in),
    .rd_en   (cmd_pop),
    .rd_data (cmd_head),
    .count   (cmd_count_unused),
    .full    (ctrl_full),
    .empty   (cmd_empty)
  );

  // ------------------------------------------------------ burst sizing
  // Beats left before the next 4 KB page boundary (1..1024).
  assign room_bytes = 13'(PAGE_BYTES) - {1'b0, addr_reg[11:0]};
  assign room_beats = room_bytes[12:2];
  assign beats_wide = min_u11(min_u11({2'b00, rem_reg}, MAX_BURST_W), room_beats);
  assign beats_calc = beats_wide[8:0];
  assign data_ready = (32'(data_count) >= 32'(beats_calc));
  assign rem_after  = rem_reg - beats_reg;
  assign beat_last  = (beat_cnt_reg == (beats_reg - 9'd1));

  // ------------------------------------------------------ AXI outputs
  assign m_axi_awaddr  = awaddr_reg;
  assign m_axi_awlen   = awlen_reg;
  assign m_axi_awsize  = AXI_SIZE_4B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awvalid = (state_reg == ST_AW);
  assign m_axi_wvalid  = (state_reg == ST_W) && !data_empty;
  assign m_axi_wlast   = (state_reg == ST_W) && beat_last;
  assign m_axi_wdata   = data_head[31:0];
  assign m_axi_wstrb   = data_head[35:32];
  assign m_axi_bready  = (state_reg == ST_B);

  assign data_pop = m_axi_wvalid && m_axi_wready;
  assign cmd_pop  = (state_reg == ST_LOAD);

  assign overflow = overflow_reg;
  assign busy     = (state_reg != ST_IDLE) || !cmd_empty;

  // ------------------------------------------------------ next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (!cmd_empty) state_next = ST_LOAD;
      ST_LOAD: state_next = (cmd_head[39:32] == 8'd0) ? ST_IDLE : ST_CALC;
      ST_CALC: if (data_ready) state_next = ST_AW;
      ST_AW:   if (m_axi_awready) state_next = ST_W;
      ST_W:    if (data_pop && beat_last) state_next = ST_B;
      ST_B:    if (m_axi_bvalid) state_next = (rem_after != 9'd0) ? ST_CALC : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------ state / datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      rem_reg      <= '0;
      addr_reg     <= '0;
      beats_reg    <= '0;
      beat_cnt_reg <= '0;
      awaddr_reg   <= '0;
      awlen_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((data_we && data_full && !data_pop) || (ctrl_we && ctrl_full && !cmd_pop)) begin
        overflow_reg <= 1'b1;
      end
      case (state_reg)
        ST_LOAD: begin
          rem_reg  <= {1'b0, cmd_head[39:32]};
          addr_reg <= {cmd_head[31:2], 2'b00};
        end
        ST_CALC: begin
          // Address fields are captured here so they stay frozen during AW.
          beats_reg    <= beats_calc;
          awaddr_reg   <= addr_reg;
          awlen_reg    <= 8'(beats_calc - 9'd1);
          beat_cnt_reg <= '0;
        end
        ST_W: begin
          if (data_pop) beat_cnt_reg <= beat_cnt_reg + 9'd1;
        end
        ST_B: begin
          if (m_axi_bvalid) begin
            rem_reg  <= rem_after;
            addr_reg <= addr_reg + {21'd0, beats_reg, 2'b00};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DRAM_WR_ERR_CNT_EN
  logic [15:0] err_cnt_reg;
  logic        err_flag_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg  <= '0;
      err_flag_reg <= 1'b0;
    end else if (m_axi_bready && m_axi_bvalid && (m_axi_bresp != AXI_RESP_OKAY)) begin
      if (err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
      err_flag_reg <= 1'b1;
    end
  end

  assign err_cnt     = err_cnt_reg;
  assign err_flag    = err_flag_reg;
  assign unused_bits = ^{beats_wide[10:9], cmd_head[1:0], cmd_count_unused};
`else
  assign unused_bits = ^{beats_wide[10:9], cmd_head[1:0], cmd_count_unused, m_axi_bresp};
`endif

endmodule

// File: doc/udp_dram_write_ctrl.md
Name: udp_dram_write_ctrl

Overview:
Downstream stage of the UDP receive path. Buffers the 36-bit strobe+data word stream and the 40-bit len+addr command stream produced by the UDP payload receiver. Converts each command into one or more AXI4 INCR write bursts toward the DRAM controller (MIG). One burst is outstanding at a time.

Parameters:
DATA_FIFO_DEPTH, 512, data FIFO entries (power of 2, at least 256 so one whole frame fits)
CMD_FIFO_DEPTH, 4, command FIFO entries (power of 2)
MAX_BURST, 16, maximum beats per AXI burst (1..256)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data_in  in  36  [35:32] wstrb, [31:0] wdata
data_we  in  1  push data_in into data FIFO
ctrl_in  in  40  [39:32] word count len, [31:0] byte address
ctrl_we  in  1  push ctrl_in into command FIFO
data_full  out  1  data FIFO full
ctrl_full  out  1  command FIFO full
overflow  out  1  sticky; set on push to a full FIFO
busy  out  1  FSM not IDLE, or command FIFO not empty
m_axi_awaddr  out  32  burst byte address
m_axi_awlen  out  8  beats-1
m_axi_awsize  out  3  constant 3'b010
m_axi_awburst  out  2  constant 2'b01
m_axi_awvalid  out  1
m_axi_awready  in  1
m_axi_wdata  out  32
m_axi_wstrb  out  4
m_axi_wlast  out  1
m_axi_wvalid  out  1
m_axi_wready  in  1
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1

Behaviour:
- Reset (async, rst_n=0):
  - both FIFOs emptied; FSM to IDLE
  - awvalid, wvalid, wlast, bready, overflow, busy all 0
  - awaddr and awlen 0
  - Reset asserted mid-burst abandons the burst; no AXI recovery is attempted.
- FIFOs: first-word-fall-through, same clock.
  - Push while full: word or command dropped, overflow set until reset.
  - No ready is returned to the producer; data_full and ctrl_full are status only.
- FSM states: IDLE, LOAD, CALC, AW, W, B.
- IDLE -> LOAD when the command FIFO is non-empty.
- LOAD:
  - pop the command; rem <= len; addr <= {ctrl_in[31:2], 2'b00} (low bits forced 0)
  - len == 0: command discarded, return to IDLE.
- CALC:
  - beats = min(rem, MAX_BURST, (4096 - addr[11:0]) >> 2); bursts never cross a 4 KB boundary.
  - Stay in CALC until the data FIFO count >= beats, then -> AW.
- AW:
  - awvalid=1, awaddr=addr, awlen=beats-1.
  - awvalid is held until awready; no address field changes while valid.
  - On handshake -> W.
- W:
  - wvalid=1 while the FIFO is non-empty; wdata/wstrb come from the FIFO head.
  - Pop on wvalid & wready.
  - wlast=1 on beat index beats-1.
  - The W handshake that carries wlast -> B.
- B:
  - bready=1; on bvalid: rem <= rem - beats, addr <= addr + 4*beats.
  - -> CALC if rem != 0, else IDLE.
- Arithmetic:
  - rem is 9 bits; beat counter is 9 bits.
  - addr wraps modulo 2^32 (no saturation).
- Back-to-back: a command queued during a burst is loaded on the IDLE cycle after B completes; minimum 1 idle cycle between commands.
- Simultaneous push and pop on the same FIFO: both take effect; a full FIFO that is popping accepts the push.
- Latency: ctrl_we to awvalid is at least 4 cycles (FIFO, IDLE, LOAD, CALC) when data is already buffered.
- Non-OKAY bresp is ignored unless the optional feature is compiled in.

Optional Feature:
Macro DRAM_WR_ERR_CNT_EN.
- Defined:
  - adds output err_cnt (16 bits), incremented on each B handshake with bresp != 2'b00, saturating at 16'hFFFF.
  - adds output err_flag (1 bit), sticky on the same condition.
  - Both are cleared by reset.
- Undefined: the ports do not exist and bresp is unused.

Decomposition:
- Shared package holds:
  - AXI_SIZE_4B = 3'b010, AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00
  - PAGE_BYTES = 4096
  - FSM state encodings
- Sub-module sync_fifo (parameters WIDTH and DEPTH; outputs count, full, empty; FWFT), instantiated twice: 36x512 for data, 40x4 for commands.

Test Plan:
- 4 words pushed, then ctrl len=4, addr=0x1000; ready always 1 -> one burst: awaddr=0x1000, awlen=3, 4 beats with wlast on the 4th, data in order, busy drops after B.
- len=40, addr=0x2000, MAX_BURST=16 -> three bursts: awlen 15/15/7 at 0x2000, 0x2040, 0x2080.
- len=8, addr=0x2FF8 -> 4 KB split: bursts awlen=1 at 0x2FF8 and awlen=5 at 0x3000.
- awready and wready randomly deasserted; bvalid delayed 10 cycles -> AXI fields stable while valid, no dropped or duplicated beats, no new AW before B.
- 513 data pushes with no command -> data_full=1 after 512, overflow=1; rst_n pulsed low mid-burst -> awvalid, wvalid and overflow 0 immediately, FIFOs empty.
- With DRAM_WR_ERR_CNT_EN: bresp=2'b10 on 2 of 3 bursts -> err_cnt=2, err_flag=1.
